// File: rtl/regfile_port_arbiter_pkg.sv
// regfile_arb_pkg
//   Shared definitions for the register-file port arbiter:
//   - default geometry of the register file and the requester count
//   - rr_pick(): round-robin one-hot pick, used by rr_arbiter
//   - wr_req_t: one requester's write payload at the default geometry
package regfile_arb_pkg;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_WIDTH      = 64;
    localparam int DEF_DEPTH      = 24;
    localparam int DEF_DEPTH_BITS = 5;

    // Widest requester vector rr_pick handles; callers zero-pad up to it.
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic [DEF_DEPTH_BITS-1:0] addr;
        logic [DEF_WIDTH-1:0]      data;
        logic [DEF_WIDTH-1:0]      mask;
    } wr_req_t;

    // Scan n requesters starting at ptr, wrapping modulo n; the first
    // asserted request wins. Returns a one-hot grant, or zero if idle.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer.
//   Ports:
//     clk, rst  clock and synchronous active-high reset
//     req       per-requester request, level
//     gnt       one-hot grant, combinational from req and the pointer
//     idx       binary index of the granted requester (0 when idle)
//   After a grant to k the pointer moves to (k+1) mod N; with no grant it holds.
//   While rst is high no grant is issued.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0]      r_ptr;
    logic [MAX_REQ-1:0] w_req_pad;
    logic [2:0]         w_ptr_pad;
    logic [MAX_REQ-1:0] w_pick;

    always_comb begin
        w_req_pad         = '0;
        w_req_pad[N-1:0]  = req;
        w_ptr_pad         = '0;
        w_ptr_pad[IW-1:0] = r_ptr;
    end

    assign w_pick = rr_pick(w_req_pad, w_ptr_pad, N);
    assign gnt    = rst ? '0 : w_pick[N-1:0];

    always_comb begin
        idx = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) idx = IW'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (|gnt) begin
            r_ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Shares one write port and one read port of a flip-flop register file
//   among N_REQ requesters with independent round-robin arbitration per port.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     wr_req/wr_addr_i/wr_data_i/wr_mask_i, wr_gnt   write channel (packed per requester)
//     rd_req/rd_addr_i, rd_gnt                       read channel
//     rd_rsp_valid, rd_rsp_data     one-cycle response pulse + shared registered data
//     rf_*                          register-file controls (wr_en, rd_en, wr_bit_en active-low)
//     addr_err                      sticky: a granted transfer addressed >= DEPTH
//   Handshake: a requester holds req and payload stable until it sees its gnt;
//   the transfer happens at the posedge where req[k] & gnt[k] is high.
//   Out-of-range transfers are still granted (no deadlock) but the write is
//   dropped and the read returns zero.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DEPTH_BITS = DEF_DEPTH_BITS,
    parameter int BYPASS     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            wr_req,
    input  logic [N_REQ*DEPTH_BITS-1:0] wr_addr_i,
    input  logic [N_REQ*WIDTH-1:0]      wr_data_i,
    input  logic [N_REQ*WIDTH-1:0]      wr_mask_i,
    output logic [N_REQ-1:0]            wr_gnt,
    input  logic [N_REQ-1:0]            rd_req,
    input  logic [N_REQ*DEPTH_BITS-1:0] rd_addr_i,
    output logic [N_REQ-1:0]            rd_gnt,
    output logic [N_REQ-1:0]            rd_rsp_valid,
    output logic [WIDTH-1:0]            rd_rsp_data,
    output logic [DEPTH_BITS-1:0]       rf_wr_addr,
    output logic [WIDTH-1:0]            rf_wr_data,
    output logic [WIDTH-1:0]            rf_wr_bit_en,
    output logic                        rf_wr_en,
    output logic [DEPTH_BITS-1:0]       rf_rd_addr,
    output logic                        rf_rd_en,
    input  logic [WIDTH-1:0]            rf_rd_data,
    output logic                        addr_err
);

    localparam int                  IW      = $clog2(N_REQ);
    localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS + 1)'(DEPTH);

    logic [IW-1:0]         w_wr_idx;
    logic [IW-1:0]         w_rd_idx;
    logic                  w_wr_any;
    logic                  w_rd_any;
    logic [DEPTH_BITS-1:0] w_wr_addr;
    logic [WIDTH-1:0]      w_wr_data;
    logic [WIDTH-1:0]      w_wr_mask;
    logic [DEPTH_BITS-1:0] w_rd_addr;
    logic                  w_wr_oor;
    logic                  w_rd_oor;
    logic                  w_wr_do;
    logic                  w_rd_do;
    logic [WIDTH-1:0]      w_rsp_next;

    logic [N_REQ-1:0]      r_rsp_valid;
    logic [WIDTH-1:0]      r_rsp_data;
    logic                  r_addr_err;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt),
        .idx (w_wr_idx)
    );

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt),
        .idx (w_rd_idx)
    );

    // Winner payload select; idx is 0 when idle, harmless because the
    // enables below are deasserted then.
    assign w_wr_any  = |wr_gnt;
    assign w_rd_any  = |rd_gnt;
    assign w_wr_addr = wr_addr_i[int'(w_wr_idx)*DEPTH_BITS +: DEPTH_BITS];
    assign w_wr_data = wr_data_i[int'(w_wr_idx)*WIDTH +: WIDTH];
    assign w_wr_mask = wr_mask_i[int'(w_wr_idx)*WIDTH +: WIDTH];
    assign w_rd_addr = rd_addr_i[int'(w_rd_idx)*DEPTH_BITS +: DEPTH_BITS];

    assign w_wr_oor = ({1'b0, w_wr_addr} >= DEPTH_C);
    assign w_rd_oor = ({1'b0, w_rd_addr} >= DEPTH_C);
    assign w_wr_do  = w_wr_any && !w_wr_oor;
    assign w_rd_do  = w_rd_any && !w_rd_oor;

    assign rf_wr_en     = ~w_wr_do;
    assign rf_wr_addr   = w_wr_addr;
    assign rf_wr_data   = w_wr_data;
    assign rf_wr_bit_en = w_wr_do ? ~w_wr_mask : '1;
    assign rf_rd_en     = ~w_rd_do;
    assign rf_rd_addr   = w_rd_addr;

    // The register file only commits the write at the next edge, so a
    // same-cycle read sees old data; BYPASS merges the masked write bits in.
    always_comb begin
        w_rsp_next = rf_rd_data;
        if (w_rd_oor) begin
            w_rsp_next = '0;
        end else if (BYPASS != 0 && w_wr_do && w_wr_addr == w_rd_addr) begin
            w_rsp_next = (rf_rd_data & ~w_wr_mask) | (w_wr_data & w_wr_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            r_rsp_valid <= rd_gnt;
            if (w_rd_any) r_rsp_data <= w_rsp_next;
            if ((w_wr_any && w_wr_oor) || (w_rd_any && w_rd_oor)) r_addr_err <= 1'b1;
        end
    end

    // A response still in flight when reset arrives is dropped immediately.
    assign rd_rsp_valid = r_rsp_valid & {N_REQ{~rst}};
    assign rd_rsp_data  = r_rsp_data;
    assign addr_err     = r_addr_err;

endmodule
